// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, the hard-wired zero register and the requester-port index type
// for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } portIdx_t;

  function automatic portIdx_t otherPort(input portIdx_t p);
    return (p == PORT0) ? PORT1 : PORT0;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// wb_fifo: per-requester writeback queue with head outputs and a per-entry
// address/valid view used to build the Pending scoreboard.
module wb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [ADDR_W-1:0]            pushAddr,
  input  logic [DATA_W-1:0]            pushData,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output logic [ADDR_W-1:0]            headAddr,
  output logic [DATA_W-1:0]            headData,
  output logic [DEPTH-1:0][ADDR_W-1:0] entryAddr,
  output logic [DEPTH-1:0]             entryValid
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0]            wrPtr;
  logic [PTR_W-1:0]            rdPtr;
  logic [PTR_W:0]              count;
  logic [DEPTH-1:0][ADDR_W-1:0] addrMem;
  logic [DEPTH-1:0][DATA_W-1:0] dataMem;
  logic [DEPTH-1:0]            validMem;
  logic                        doPush;
  logic                        doPop;

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign doPush   = push && !full;
  assign doPop    = pop && !empty;
  assign headAddr = addrMem[rdPtr];
  assign headData = dataMem[rdPtr];
  assign entryAddr  = addrMem;
  assign entryValid = validMem;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      addrMem  <= '0;
      dataMem  <= '0;
      validMem <= '0;
    end else begin
      if (doPush) begin
        addrMem[wrPtr]  <= pushAddr;
        dataMem[wrPtr]  <= pushData;
        validMem[wrPtr] <= 1'b1;
        wrPtr           <= wrPtr + 1'b1;
      end
      if (doPop) begin
        validMem[rdPtr] <= 1'b0;
        rdPtr           <= rdPtr + 1'b1;
      end
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-port register-file writeback arbiter: queues per requester, one grant per
// cycle, registered write port. Define WB_ARB_RR_EN for round-robin arbitration.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              ReqValid0,
  output logic              ReqReady0,
  input  logic [ADDR_W-1:0] ReqAddr0,
  input  logic [DATA_W-1:0] ReqData0,
  input  logic              ReqValid1,
  output logic              ReqReady1,
  input  logic [ADDR_W-1:0] ReqAddr1,
  input  logic [DATA_W-1:0] ReqData1,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic [31:0]       Pending
);

  logic                              full0, full1, empty0, empty1;
  logic                              pop0, pop1;
  logic [ADDR_W-1:0]                 headAddr0, headAddr1;
  logic [DATA_W-1:0]                 headData0, headData1;
  logic [FIFO_DEPTH-1:0][ADDR_W-1:0] entryAddr0, entryAddr1;
  logic [FIFO_DEPTH-1:0]             entryValid0, entryValid1;
  logic                              grantValid;
  portIdx_t                          grantPort;
  logic [ADDR_W-1:0]                 grantAddr;
  logic [DATA_W-1:0]                 grantData;

  assign ReqReady0 = !full0;
  assign ReqReady1 = !full1;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) fifo0 (
    .clk(Clk), .rst_n(Rst_n),
    .push(ReqValid0), .pushAddr(ReqAddr0), .pushData(ReqData0),
    .pop(pop0), .full(full0), .empty(empty0),
    .headAddr(headAddr0), .headData(headData0),
    .entryAddr(entryAddr0), .entryValid(entryValid0)
  );

  wb_fifo #(.DEPTH(FIFO_DEPTH)) fifo1 (
    .clk(Clk), .rst_n(Rst_n),
    .push(ReqValid1), .pushAddr(ReqAddr1), .pushData(ReqData1),
    .pop(pop1), .full(full1), .empty(empty1),
    .headAddr(headAddr1), .headData(headData1),
    .entryAddr(entryAddr1), .entryValid(entryValid1)
  );

`ifdef WB_ARB_RR_EN
  portIdx_t rrPtr;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rrPtr <= PORT0;
    end else if (grantValid) begin
      rrPtr <= otherPort(grantPort);
    end
  end

  always_comb begin
    grantValid = !empty0 || !empty1;
    grantPort  = PORT0;
    if (!empty0 && !empty1) begin
      grantPort = rrPtr;
    end else if (!empty1) begin
      grantPort = PORT1;
    end
  end
`else
  always_comb begin
    grantValid = !empty0 || !empty1;
    grantPort  = empty0 ? PORT1 : PORT0;
  end
`endif

  assign pop0      = grantValid && (grantPort == PORT0);
  assign pop1      = grantValid && (grantPort == PORT1);
  assign grantAddr = (grantPort == PORT0) ? headAddr0 : headAddr1;
  assign grantData = (grantPort == PORT0) ? headData0 : headData1;

  // A zero-register grant still consumes the slot but never raises RegWrite.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else begin
      RegWrite <= grantValid && (grantAddr != ZERO_REG);
      if (grantValid) begin
        WriteRegister <= grantAddr;
        WriteData     <= grantData;
      end
    end
  end

  always_comb begin
    Pending = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (entryValid0[i]) Pending[entryAddr0[i]] = 1'b1;
      if (entryValid1[i]) Pending[entryAddr1[i]] = 1'b1;
    end
    if (RegWrite) Pending[WriteRegister] = 1'b1;
    Pending[ZERO_REG] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; expectations follow WB_ARB_RR_EN when defined.
module tb_regfile_wb_arbiter;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        ReqValid0 = 1'b0, ReqValid1 = 1'b0;
  logic        ReqReady0, ReqReady1;
  logic [4:0]  ReqAddr0 = '0, ReqAddr1 = '0;
  logic [31:0] ReqData0 = '0, ReqData1 = '0;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [31:0] Pending;

  int checks = 0;
  int failures = 0;

  logic [4:0]  outAddr[$];
  logic [31:0] outData[$];
  logic        readyHist[$];
  logic [4:0]  s0[4];
  logic [4:0]  s1[4];
  int          n0, n1;
  logic        sawStall1;

  regfile_wb_arbiter #(.FIFO_DEPTH(2)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .ReqValid0(ReqValid0), .ReqReady0(ReqReady0), .ReqAddr0(ReqAddr0), .ReqData0(ReqData0),
    .ReqValid1(ReqValid1), .ReqReady1(ReqReady1), .ReqAddr1(ReqAddr1), .ReqData1(ReqData1),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .Pending(Pending)
  );

  always #5 Clk = ~Clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
    if (RegWrite) begin
      outAddr.push_back(WriteRegister);
      outData.push_back(WriteData);
    end
    readyHist.push_back(ReqReady1);
  endtask

  task automatic clearLogs();
    outAddr.delete();
    outData.delete();
    readyHist.delete();
    sawStall1 = 1'b0;
  endtask

  // Drives s0/s1 as far as each port's ready allows, for a fixed cycle budget.
  task automatic runStreams(input int cycles);
    int i0 = 0;
    int i1 = 0;
    logic acc0, acc1;
    for (int c = 0; c < cycles; c++) begin
      ReqValid0 = (i0 < n0);
      ReqAddr0  = (i0 < n0) ? s0[i0] : 5'd0;
      ReqData0  = 32'hA500_0000 | 32'(ReqAddr0);
      ReqValid1 = (i1 < n1);
      ReqAddr1  = (i1 < n1) ? s1[i1] : 5'd0;
      ReqData1  = 32'hA500_0000 | 32'(ReqAddr1);
      acc0 = ReqValid0 && ReqReady0;
      acc1 = ReqValid1 && ReqReady1;
      if (ReqValid1 && !ReqReady1) sawStall1 = 1'b1;
      step();
      if (acc0) i0++;
      if (acc1) i1++;
    end
    ReqValid0 = 1'b0;
    ReqValid1 = 1'b0;
  endtask

  task automatic doReset();
    #1 Rst_n = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    logic [4:0] expOrder[6];
    logic [4:0] p1Seen[$];
    int regWriteCount;

    // Reset state
    #2;
    checkVal("rst_regwrite", 32'(RegWrite), 32'd0);
    checkVal("rst_wreg", 32'(WriteRegister), 32'd0);
    checkVal("rst_wdata", WriteData, 32'd0);
    checkVal("rst_pending", Pending, 32'd0);
    checkVal("rst_ready0", 32'(ReqReady0), 32'd1);
    checkVal("rst_ready1", 32'(ReqReady1), 32'd1);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;

    // Single write: accept at edge 1, visible after edge 2, cleared after edge 3
    clearLogs();
    ReqValid0 = 1'b1; ReqAddr0 = 5'd5; ReqData0 = 32'hDEAD_BEEF;
    step();
    ReqValid0 = 1'b0;
    checkVal("sw_e1_regwrite", 32'(RegWrite), 32'd0);
    checkVal("sw_e1_pending", Pending, 32'h0000_0020);
    step();
    checkVal("sw_e2_regwrite", 32'(RegWrite), 32'd1);
    checkVal("sw_e2_wreg", 32'(WriteRegister), 32'd5);
    checkVal("sw_e2_wdata", WriteData, 32'hDEAD_BEEF);
    checkVal("sw_e2_pending", Pending, 32'h0000_0020);
    step();
    checkVal("sw_e3_regwrite", 32'(RegWrite), 32'd0);
    checkVal("sw_e3_wreg_hold", 32'(WriteRegister), 32'd5);
    checkVal("sw_e3_wdata_hold", WriteData, 32'hDEAD_BEEF);
    checkVal("sw_e3_pending", Pending, 32'd0);

    // Contention: p0 1,2,3 against p1 9,10,11
    clearLogs();
    s0 = '{5'd1, 5'd2, 5'd3, 5'd0}; n0 = 3;
    s1 = '{5'd9, 5'd10, 5'd11, 5'd0}; n1 = 3;
    runStreams(10);
`ifdef WB_ARB_RR_EN
    expOrder = '{5'd1, 5'd9, 5'd2, 5'd10, 5'd3, 5'd11};
`else
    expOrder = '{5'd1, 5'd2, 5'd3, 5'd9, 5'd10, 5'd11};
    checkVal("ct_stall1", 32'(sawStall1), 32'd1);
`endif
    checkVal("ct_count", 32'(outAddr.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < outAddr.size()) begin
        checkVal($sformatf("ct_order%0d", i), 32'(outAddr[i]), 32'(expOrder[i]));
        checkVal($sformatf("ct_data%0d", i), outData[i], 32'hA500_0000 | 32'(expOrder[i]));
      end
    end
    checkVal("ct_pending_idle", Pending, 32'd0);

    // Full queue on port 1 while port 0 keeps winning
    clearLogs();
    s0 = '{5'd20, 5'd20, 5'd20, 5'd20}; n0 = 4;
    s1 = '{5'd21, 5'd22, 5'd23, 5'd0}; n1 = 3;
    runStreams(10);
    checkVal("fq_ready1_e2", 32'(readyHist[1]), 32'd0);
`ifndef WB_ARB_RR_EN
    checkVal("fq_ready1_e3", 32'(readyHist[2]), 32'd0);
    checkVal("fq_ready1_e5", 32'(readyHist[4]), 32'd0);
    checkVal("fq_ready1_e6", 32'(readyHist[5]), 32'd1);
    checkVal("fq_first_p1_slot", 32'(outAddr.size() > 4 ? outAddr[4] : 5'd0), 32'd21);
`endif
    checkVal("fq_count", 32'(outAddr.size()), 32'd7);
    foreach (outAddr[i]) if (outAddr[i] != 5'd20) p1Seen.push_back(outAddr[i]);
    checkVal("fq_p1_count", 32'(p1Seen.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < p1Seen.size()) checkVal($sformatf("fq_p1_order%0d", i), 32'(p1Seen[i]), 32'(21 + i));
    end

    // Zero register: popped without a write, then the next entry follows one cycle later
    clearLogs();
    ReqValid0 = 1'b1; ReqAddr0 = 5'd0; ReqData0 = 32'h1234_5678;
    step();
    checkVal("z_e1_pending", Pending, 32'd0);
    ReqAddr0 = 5'd7; ReqData0 = 32'h0000_0077;
    step();
    ReqValid0 = 1'b0;
    checkVal("z_e2_regwrite", 32'(RegWrite), 32'd0);
    checkVal("z_e2_pending", Pending, 32'h0000_0080);
    step();
    checkVal("z_e3_regwrite", 32'(RegWrite), 32'd1);
    checkVal("z_e3_wreg", 32'(WriteRegister), 32'd7);
    checkVal("z_e3_wdata", WriteData, 32'h0000_0077);
    step();
    checkVal("z_e4_pending", Pending, 32'd0);

    // Reset mid-flight
    clearLogs();
    ReqValid0 = 1'b1; ReqAddr0 = 5'd3; ReqData0 = 32'h3;
    ReqValid1 = 1'b1; ReqAddr1 = 5'd12; ReqData1 = 32'hC;
    step();
    ReqAddr0 = 5'd4; ReqAddr1 = 5'd13;
    step();
    ReqValid0 = 1'b0; ReqValid1 = 1'b0;
    checkVal("rm_pre_pending", Pending, 32'h0000_3018);
    checkVal("rm_pre_ready1", 32'(ReqReady1), 32'd0);
    Rst_n = 1'b0;
    #1;
    checkVal("rm_regwrite", 32'(RegWrite), 32'd0);
    checkVal("rm_pending", Pending, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    clearLogs();
    regWriteCount = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (RegWrite) regWriteCount++;
    end
    checkVal("rm_no_emit", 32'(regWriteCount), 32'd0);
    checkVal("rm_ready0", 32'(ReqReady0), 32'd1);
    checkVal("rm_ready1", 32'(ReqReady1), 32'd1);
    checkVal("rm_post_pending", Pending, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
